// File: rtl/bp_stream_io_cmd_arbiter.sv
// Shares one bedrock I/O command port between two host-side requesters
// (r0 = NBF loader, r1 = host MMIO/debug master). Commands are arbitrated
// round-robin; the requester ID of every issued command is queued in order so
// each returning io_resp is steered back to the requester that issued it.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   rX_cmd_i/_v_i/_yumi_o     requester X command channel (valid/yumi)
//   rX_resp_o/_v_o/_ready_i   requester X response channel (valid/ready)
//   io_cmd_o/_v_o/_yumi_i     arbitrated command to chip (valid/yumi)
//   io_resp_i/_v_i/_ready_o   response from chip (valid/ready)
//   outstanding_o             number of in-flight commands
//   idle_o                    nothing in flight and no requester asking
//   error_o                   sticky: response arrived with nothing in flight
module bp_stream_io_cmd_arbiter #(
   parameter int unsigned msg_width_p       = 128,
   parameter int unsigned max_outstanding_p = 4,
   parameter int unsigned lg_outstanding_lp = $clog2(max_outstanding_p + 1)
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,

   input  logic [msg_width_p-1:0]       r0_cmd_i,
   input  logic                         r0_cmd_v_i,
   output logic                         r0_cmd_yumi_o,
   output logic [msg_width_p-1:0]       r0_resp_o,
   output logic                         r0_resp_v_o,
   input  logic                         r0_resp_ready_i,

   input  logic [msg_width_p-1:0]       r1_cmd_i,
   input  logic                         r1_cmd_v_i,
   output logic                         r1_cmd_yumi_o,
   output logic [msg_width_p-1:0]       r1_resp_o,
   output logic                         r1_resp_v_o,
   input  logic                         r1_resp_ready_i,

   output logic [msg_width_p-1:0]       io_cmd_o,
   output logic                         io_cmd_v_o,
   input  logic                         io_cmd_yumi_i,
   input  logic [msg_width_p-1:0]       io_resp_i,
   input  logic                         io_resp_v_i,
   output logic                         io_resp_ready_o,

   output logic [lg_outstanding_lp-1:0] outstanding_o,
   output logic                         idle_o,
   output logic                         error_o
);

   localparam int unsigned ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
   localparam logic [ptr_w_lp-1:0]          last_slot_lp = ptr_w_lp'(max_outstanding_p - 1);
   localparam logic [lg_outstanding_lp-1:0] max_cnt_lp   = lg_outstanding_lp'(max_outstanding_p);

   // One-bit requester ID per in-flight command, circular buffer
   logic [max_outstanding_p-1:0]  id_mem_q, id_mem_d;
   logic [ptr_w_lp-1:0]           wptr_q, wptr_d;
   logic [ptr_w_lp-1:0]           rptr_q, rptr_d;
   logic [lg_outstanding_lp-1:0]  count_q, count_d;
   logic                          lock_q, lock_d;
   logic                          lock_id_q, lock_id_d;
   logic                          last_grant_q, last_grant_d;
   logic                          error_q, error_d;

   logic                          grant;
   logic                          issue_ok;
   logic                          empty;
   logic                          head_id;
   logic                          push;
   logic                          pop;

   // State registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         id_mem_q     <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         lock_q       <= 1'b0;
         lock_id_q    <= 1'b0;
         last_grant_q <= 1'b1;
         error_q      <= 1'b0;
      end else begin
         id_mem_q     <= id_mem_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
         lock_q       <= lock_d;
         lock_id_q    <= lock_id_d;
         last_grant_q <= last_grant_d;
         error_q      <= error_d;
      end
   end

   // Arbitration, handshakes, response steering and next state
   always_comb begin
      id_mem_d     = id_mem_q;
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      count_d      = count_q;
      lock_d       = lock_q;
      lock_id_d    = lock_id_q;
      last_grant_d = last_grant_q;
      error_d      = error_q;

      // Registered count only: a pop this cycle does not open a slot until next cycle
      issue_ok = (count_q < max_cnt_lp);
      empty    = (count_q == '0);
      head_id  = id_mem_q[rptr_q];

      if (lock_q)                        grant = lock_id_q;
      else if (r0_cmd_v_i ^ r1_cmd_v_i)  grant = r1_cmd_v_i;
      else                               grant = ~last_grant_q;

      // Gated by reset_n_i so no valid leaks out while reset is asserted
      io_cmd_v_o    = reset_n_i & issue_ok & (grant ? r1_cmd_v_i : r0_cmd_v_i);
      io_cmd_o      = grant ? r1_cmd_i : r0_cmd_i;
      push          = io_cmd_v_o & io_cmd_yumi_i;
      r0_cmd_yumi_o = push & ~grant;
      r1_cmd_yumi_o = push &  grant;

      io_resp_ready_o = ~empty & (head_id ? r1_resp_ready_i : r0_resp_ready_i);
      r0_resp_v_o     = io_resp_v_i & ~empty & ~head_id;
      r1_resp_v_o     = io_resp_v_i & ~empty &  head_id;
      r0_resp_o       = io_resp_i;
      r1_resp_o       = io_resp_i;
      pop             = io_resp_v_i & io_resp_ready_o;

      if (push) begin
         id_mem_d[wptr_q] = grant;
         wptr_d           = (wptr_q == last_slot_lp) ? '0 : ptr_w_lp'(wptr_q + 1'b1);
         last_grant_d     = grant;
      end
      if (pop) begin
         rptr_d = (rptr_q == last_slot_lp) ? '0 : ptr_w_lp'(rptr_q + 1'b1);
      end

      if (push && !pop)      count_d = lg_outstanding_lp'(count_q + 1'b1);
      else if (pop && !push) count_d = lg_outstanding_lp'(count_q - 1'b1);

      // A presented but unconsumed command pins the grant until the chip takes it
      if (push) begin
         lock_d = 1'b0;
      end else if (io_cmd_v_o) begin
         lock_d    = 1'b1;
         lock_id_d = grant;
      end

      if (io_resp_v_i && empty) error_d = 1'b1;
   end

   assign outstanding_o = count_q;
   assign idle_o        = (count_q == '0) & ~r0_cmd_v_i & ~r1_cmd_v_i;
   assign error_o       = error_q;

   // A locked requester must keep its command valid until it is consumed
   a_lock_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      lock_q |-> (lock_id_q ? r1_cmd_v_i : r0_cmd_v_i));

endmodule

// File: tb/tb_bp_stream_io_cmd_arbiter.sv
module tb_bp_stream_io_cmd_arbiter;

   localparam int unsigned W = 128;

   typedef struct {
      logic         id;
      logic [W-1:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] r0_cmd, r1_cmd, r0_resp, r1_resp, io_cmd, io_resp;
   logic         r0_cmd_v, r1_cmd_v, r0_yumi, r1_yumi;
   logic         r0_resp_v, r1_resp_v, r0_ready, r1_ready;
   logic         io_cmd_v, io_yumi, io_resp_v, io_resp_ready;
   logic [2:0]   outstanding;
   logic         idle, error;

   int n_checks = 0;
   int n_pass   = 0;
   exp_t cmd_q[$];
   exp_t resp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   bp_stream_io_cmd_arbiter #(.msg_width_p(W), .max_outstanding_p(4)) dut (
      .clk_i(clk), .reset_n_i(rst_n),
      .r0_cmd_i(r0_cmd), .r0_cmd_v_i(r0_cmd_v), .r0_cmd_yumi_o(r0_yumi),
      .r0_resp_o(r0_resp), .r0_resp_v_o(r0_resp_v), .r0_resp_ready_i(r0_ready),
      .r1_cmd_i(r1_cmd), .r1_cmd_v_i(r1_cmd_v), .r1_cmd_yumi_o(r1_yumi),
      .r1_resp_o(r1_resp), .r1_resp_v_o(r1_resp_v), .r1_resp_ready_i(r1_ready),
      .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_yumi_i(io_yumi),
      .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_ready_o(io_resp_ready),
      .outstanding_o(outstanding), .idle_o(idle), .error_o(error)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      r0_cmd = '0; r1_cmd = '0; r0_cmd_v = 0; r1_cmd_v = 0;
      r0_ready = 0; r1_ready = 0; io_yumi = 0; io_resp = '0; io_resp_v = 0;
   endtask

   task automatic do_reset();
      zero_inputs();
      #1 rst_n = 0;
      @(negedge clk);
      check("rst_io_cmd_v", io_cmd_v, 0);
      check("rst_io_resp_ready", io_resp_ready, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_idle", idle, 1);
      check("rst_error", error, 0);
      step();
      rst_n = 1;
   endtask

   // Monitor: compares every completed handshake against the scoreboards
   always @(negedge clk) begin
      if (rst_n) begin
         if (io_cmd_v && io_yumi) begin
            if (cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
            else begin
               mon_e = cmd_q.pop_front();
               check("cmd_data", io_cmd, mon_e.data);
               check("cmd_yumi_steer", {r1_yumi, r0_yumi}, mon_e.id ? 2'b10 : 2'b01);
            end
         end
         if (io_resp_v && io_resp_ready) begin
            if (resp_q.size() == 0) check("resp_unexpected", 1, 0);
            else begin
               mon_e = resp_q.pop_front();
               check("resp_v_steer", {r1_resp_v, r0_resp_v}, mon_e.id ? 2'b10 : 2'b01);
               check("resp_data", mon_e.id ? r1_resp : r0_resp, mon_e.data);
            end
         end
      end
   end

   initial begin
      rst_n = 1;
      zero_inputs();
      do_reset();

      // Outputs stay quiet while reset is held even with active inputs
      rst_n = 0;
      r0_cmd_v = 1; io_yumi = 1;
      @(negedge clk);
      check("rst_gate_cmd_v", io_cmd_v, 0);
      check("rst_gate_yumi", r0_yumi, 0);
      r0_cmd_v = 0; io_yumi = 0;
      step();
      rst_n = 1;

      // Single r0 command and its response
      step();
      r0_cmd = 128'hA; r0_cmd_v = 1; io_yumi = 1; cmd_q.push_back('{1'b0, 128'hA});
      step();
      r0_cmd_v = 0; io_yumi = 0;
      @(negedge clk);
      check("single_outstanding_1", outstanding, 1);
      check("single_not_idle", idle, 0);
      step();
      io_resp = 128'hF00D; io_resp_v = 1; r0_ready = 1; r1_ready = 1;
      resp_q.push_back('{1'b0, 128'hF00D});
      @(negedge clk);
      check("single_r1_resp_v", r1_resp_v, 0);
      step();
      io_resp_v = 0;
      @(negedge clk);
      check("single_outstanding_0", outstanding, 0);

      // Round robin from reset fills the ID FIFO 0,1,0,1
      do_reset();
      r0_cmd = 128'hA0; r1_cmd = 128'hB1; r0_ready = 1; r1_ready = 1;
      r0_cmd_v = 1; r1_cmd_v = 1; io_yumi = 1;
      cmd_q.push_back('{1'b0, 128'hA0}); cmd_q.push_back('{1'b1, 128'hB1});
      cmd_q.push_back('{1'b0, 128'hA0}); cmd_q.push_back('{1'b1, 128'hB1});
      repeat (4) @(posedge clk);
      #1 io_yumi = 0;
      @(negedge clk);
      check("full_cmd_v", io_cmd_v, 0);
      check("full_outstanding", outstanding, 4);

      // Pop while full: issue resumes only on the following cycle
      step();
      io_resp = 128'hC0; io_resp_v = 1; resp_q.push_back('{1'b0, 128'hC0});
      @(negedge clk);
      check("no_bypass_cmd_v", io_cmd_v, 0);
      step();
      io_resp_v = 0;
      @(negedge clk);
      check("resume_cmd_v", io_cmd_v, 1);
      check("resume_grant_r0", io_cmd, 128'hA0);
      check("resume_outstanding", outstanding, 3);

      // Push and pop in the same cycle
      step();
      io_yumi = 1; cmd_q.push_back('{1'b0, 128'hA0});
      io_resp = 128'hC1; io_resp_v = 1; resp_q.push_back('{1'b1, 128'hC1});
      step();
      io_yumi = 0; io_resp_v = 0; r0_cmd_v = 0; r1_cmd_v = 0;
      @(negedge clk);
      check("pushpop_outstanding", outstanding, 3);

      // Head requester not ready: response held off
      step();
      r0_ready = 0; io_resp = 128'hD0; io_resp_v = 1;
      @(negedge clk);
      check("bp_resp_ready", io_resp_ready, 0);
      check("bp_resp_v", {r1_resp_v, r0_resp_v}, 2'b01);
      step();
      r0_ready = 1; resp_q.push_back('{1'b0, 128'hD0});
      step();
      io_resp = 128'hD1; resp_q.push_back('{1'b1, 128'hD1});
      step();
      io_resp = 128'hD2; resp_q.push_back('{1'b0, 128'hD2});
      step();
      io_resp_v = 0;
      @(negedge clk);
      check("drain_outstanding", outstanding, 0);
      check("drain_idle", idle, 1);

      // Lock: r1 stalled by the chip keeps the grant while r0 waits
      step();
      r1_cmd = 128'hC1; r1_cmd_v = 1; io_yumi = 1; cmd_q.push_back('{1'b1, 128'hC1});
      step();
      io_yumi = 0; r1_cmd = 128'hC2;
      @(negedge clk);
      check("lock_first_cmd", io_cmd, 128'hC2);
      step();
      r0_cmd = 128'hC0; r0_cmd_v = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("lock_hold_cmd", io_cmd, 128'hC2);
         check("lock_hold_v", io_cmd_v, 1);
         check("lock_r0_no_yumi", r0_yumi, 0);
         step();
      end
      io_yumi = 1; cmd_q.push_back('{1'b1, 128'hC2});
      step();
      cmd_q.push_back('{1'b0, 128'hC0});
      step();
      io_yumi = 0; r0_cmd_v = 0; r1_cmd_v = 0;
      @(negedge clk);
      check("lock_outstanding", outstanding, 3);
      step();
      io_resp_v = 1; io_resp = 128'hE1; resp_q.push_back('{1'b1, 128'hE1});
      step();
      io_resp = 128'hE2; resp_q.push_back('{1'b1, 128'hE2});
      step();
      io_resp = 128'hE3; resp_q.push_back('{1'b0, 128'hE3});
      step();
      io_resp_v = 0;
      @(negedge clk);
      check("lock_drain_outstanding", outstanding, 0);

      // Response with nothing outstanding sets a sticky error
      step();
      io_resp = 128'hDEAD; io_resp_v = 1;
      @(negedge clk);
      check("err_resp_ready", io_resp_ready, 0);
      check("err_resp_v", {r1_resp_v, r0_resp_v}, 2'b00);
      check("err_not_yet", error, 0);
      step();
      io_resp_v = 0;
      @(negedge clk);
      check("err_set", error, 1);
      repeat (3) step();
      @(negedge clk);
      check("err_sticky", error, 1);
      do_reset();

      check("cmd_scoreboard_empty", 32'(cmd_q.size()), 0);
      check("resp_scoreboard_empty", 32'(resp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
